// File: rtl/acq_sequencer.sv
// Frame acquisition sequencer: arms on cmd_run, handshakes every frame with the
// receiver (optional trigger edge, inter-frame delay) and reports done/timeout.
module acq_sequencer #(
  parameter int ACK_TIMEOUT = 1024,
  parameter int FCNT_W      = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [31:0]       cfg_dsize,
  input  logic [FCNT_W-1:0] cfg_nframes,
  input  logic [31:0]       cfg_delay,
  input  logic              cfg_trig_en,
  input  logic              cfg_test,
  input  logic              cmd_run,
  input  logic              cmd_stop,
  input  logic              trig,
  input  logic              rx_pc,
  output logic [31:0]       rx_dsize,
  output logic              rx_test,
  output logic              rx_start,
  output logic              busy,
  output logic              done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_timeout
);

  localparam int                TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TRIG = 3'd1,
    S_WAIT_RDY  = 3'd2,
    S_START     = 3'd3,
    S_RUN       = 3'd4,
    S_DELAY     = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         dsize_q, dsize_d;
  logic                test_q, test_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                err_q, err_d;
  logic                stop_pend_q, stop_pend_d;
  logic                trig_q, trig_d;
  logic [31:0]         dly_q, dly_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  logic                trig_edge;
  logic [FCNT_W-1:0]   frame_inc;
  state_t              armed_state;

  assign trig_edge   = trig & ~trig_q;
  assign frame_inc   = fcnt_q + FCNT_ONE;
  assign armed_state = cfg_trig_en ? S_WAIT_TRIG : S_WAIT_RDY;

  always_comb begin
    state_d     = state_q;
    dsize_d     = dsize_q;
    test_d      = test_q;
    fcnt_d      = fcnt_q;
    err_d       = err_q;
    stop_pend_d = stop_pend_q;
    trig_d      = trig;
    dly_d       = dly_q;
    tmo_d       = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_run && !cmd_stop) begin
          dsize_d     = cfg_dsize;
          test_d      = cfg_test;
          fcnt_d      = '0;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = armed_state;
        end
      end
      S_WAIT_TRIG: begin
        if (cmd_stop)       state_d = S_IDLE;
        else if (trig_edge) state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        tmo_d = '0;
        if (cmd_stop)   state_d = S_IDLE;
        else if (rx_pc) state_d = S_START;
      end
      S_START: begin
        if (cmd_stop) stop_pend_d = 1'b1;
        if (!rx_pc) begin
          state_d = S_RUN;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_RUN: begin
        if (cmd_stop) stop_pend_d = 1'b1;
        if (rx_pc) begin
          fcnt_d = frame_inc;
          // A stop arriving in the completing cycle still ends the run cleanly.
          if ((cfg_nframes != '0 && frame_inc == cfg_nframes) || stop_pend_q || cmd_stop) begin
            state_d = S_DONE;
          end else if (cfg_delay == 32'd0) begin
            state_d = armed_state;
          end else begin
            dly_d   = cfg_delay;
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (cmd_stop) begin
          state_d = S_IDLE;
        end else if (dly_q <= 32'd1) begin
          state_d = armed_state;
        end else begin
          dly_d = dly_q - 32'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      dsize_q     <= '0;
      test_q      <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fcnt_q      <= '0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      trig_q      <= 1'b0;
      dly_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      dsize_q     <= dsize_d;
      test_q      <= test_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fcnt_q      <= fcnt_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
      trig_q      <= trig_d;
      dly_q       <= dly_d;
      tmo_q       <= tmo_d;
    end
  end

  assign rx_dsize    = dsize_q;
  assign rx_test     = test_q;
  assign rx_start    = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_cnt   = fcnt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: table-driven and randomized runs against
// a frame-level timing model, plus directed trigger/stop/timeout/reset sequences.
module tb_acq_sequencer;

  localparam int ACK_TO = 1024;
  localparam int FW     = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [31:0]   cfg_dsize = '0;
  logic [FW-1:0] cfg_nframes = '0;
  logic [31:0]   cfg_delay = '0;
  logic          cfg_trig_en = 1'b0;
  logic          cfg_test = 1'b0;
  logic          cmd_run = 1'b0;
  logic          cmd_stop = 1'b0;
  logic          trig = 1'b0;
  logic          rx_pc;
  logic [31:0]   rx_dsize;
  logic          rx_test;
  logic          rx_start;
  logic          busy;
  logic          done;
  logic [FW-1:0] frame_cnt;
  logic          err_timeout;

  acq_sequencer #(.ACK_TIMEOUT(ACK_TO), .FCNT_W(FW)) dut (
    .aclk(aclk), .areset(areset),
    .cfg_dsize(cfg_dsize), .cfg_nframes(cfg_nframes), .cfg_delay(cfg_delay),
    .cfg_trig_en(cfg_trig_en), .cfg_test(cfg_test),
    .cmd_run(cmd_run), .cmd_stop(cmd_stop), .trig(trig), .rx_pc(rx_pc),
    .rx_dsize(rx_dsize), .rx_test(rx_test), .rx_start(rx_start), .busy(busy),
    .done(done), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // Event log: cycle stamps of start-request rises and frame completions.
  int            start_hi = 0;
  int            done_cnt = 0;
  int            start_q[$];
  int            end_q[$];
  logic          prev_start = 1'b0;
  logic [FW-1:0] prev_fc = '0;

  always @(negedge aclk) begin
    if (!areset) begin
      if (rx_start) start_hi++;
      if (rx_start && !prev_start) start_q.push_back(cyc);
      if (busy && frame_cnt == prev_fc + FW'(1)) end_q.push_back(cyc);
      if (done) done_cnt++;
    end
    prev_start = rx_start;
    prev_fc    = frame_cnt;
  end

  // Receiver: drops rx_pc lat_drop cycles after seeing rx_start, raises it lat_busy later.
  int lat_drop = 2;
  int lat_busy = 8;
  bit rx_mode  = 1'b0;
  bit rx_force = 1'b1;
  int rx_ph    = 0;
  int rx_cnt   = 0;

  always @(negedge aclk) begin
    if (rx_mode) begin
      rx_pc = rx_force;
    end else begin
      case (rx_ph)
        0: begin
          rx_pc = 1'b1;
          if (rx_start) begin rx_ph = 1; rx_cnt = lat_drop; end
        end
        1: begin
          rx_cnt--;
          if (rx_cnt <= 0) begin rx_pc = 1'b0; rx_ph = 2; rx_cnt = lat_busy; end
        end
        default: begin
          rx_cnt--;
          if (rx_cnt <= 0) begin rx_pc = 1'b1; rx_ph = 0; end
        end
      endcase
    end
  end

  typedef struct {
    logic [31:0] dsize;
    logic        test;
    logic [15:0] nfr;
    logic [31:0] dly;
    int          ldrop;
    int          lbusy;
    int          exp_fc;
    int          exp_starts;
    int          exp_done;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge aclk);
      if (!busy) begin ok = 1; break; end
    end
    chk($sformatf("%s_wait_idle", name), ok, 1);
  endtask

  task automatic wait_fc(input int v, input int budget, input string name);
    int ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge aclk);
      if (int'(frame_cnt) == v) begin ok = 1; break; end
    end
    chk($sformatf("%s_wait_fc%0d", name, v), ok, 1);
  endtask

  task automatic wait_start(input logic lv, input int budget, input string name);
    int ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge aclk);
      if (rx_start == lv) begin ok = 1; break; end
    end
    chk($sformatf("%s_wait_start%0d", name, lv), ok, 1);
  endtask

  task automatic pulse_run();
    cmd_run = 1'b1;
    @(negedge aclk);
    cmd_run = 1'b0;
  endtask

  task automatic pulse_stop();
    cmd_stop = 1'b1;
    @(negedge aclk);
    cmd_stop = 1'b0;
  endtask

  // A finite run of N frames gives N start handshakes, N completions, one done pulse.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    r            = v;
    r.exp_fc     = int'(v.nfr);
    r.exp_starts = int'(v.nfr);
    r.exp_done   = 1;
    return r;
  endfunction

  // Timing rule: a start rises one cycle after cmd_run, and delay+1 cycles after
  // the previous frame completes (delay idle cycles, then one readiness cycle).
  task automatic run_check(input vec_t v, input string name);
    int s0, e0, d0, run_c;
    cfg_dsize   = v.dsize;
    cfg_test    = v.test;
    cfg_nframes = v.nfr;
    cfg_delay   = v.dly;
    cfg_trig_en = 1'b0;
    lat_drop    = v.ldrop;
    lat_busy    = v.lbusy;
    s0 = start_q.size();
    e0 = end_q.size();
    d0 = done_cnt;
    pulse_run();
    run_c = cyc;
    cfg_dsize = $urandom;
    cfg_test  = ~v.test;
    @(negedge aclk);
    pulse_run();
    wait_idle(20000, name);
    @(negedge aclk);
    chk($sformatf("%s_starts", name), start_q.size() - s0, v.exp_starts);
    chk($sformatf("%s_frames", name), end_q.size() - e0, v.exp_fc);
    chk($sformatf("%s_frame_cnt", name), int'(frame_cnt), v.exp_fc);
    chk($sformatf("%s_done", name), done_cnt - d0, v.exp_done);
    chk($sformatf("%s_rx_dsize", name), int'(rx_dsize), int'(v.dsize));
    chk($sformatf("%s_rx_test", name), int'(rx_test), int'(v.test));
    chk($sformatf("%s_err", name), int'(err_timeout), 0);
    if (start_q.size() > s0) chk($sformatf("%s_first_lat", name), start_q[s0] - run_c, 1);
    for (int i = 1; i < v.exp_starts; i++) begin
      if (s0 + i < start_q.size() && e0 + i - 1 < end_q.size())
        chk($sformatf("%s_gap%0d", name, i), start_q[s0 + i] - end_q[e0 + i - 1], int'(v.dly) + 1);
    end
    $display("run %s: dsize=%0d nframes=%0d delay=%0d frames=%0d done=%0d",
             name, v.dsize, v.nfr, v.dly, frame_cnt, done_cnt - d0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[4];
    int   s0, e0, d0, h0, trig_c1, trig_c2;
    vec_t pr;

    tbl[0] = '{32'd256, 1'b0, 16'd3, 32'd0, 2, 256, 3, 3, 1};
    tbl[1] = '{32'h55,  1'b1, 16'd1, 32'd5, 1, 3,   1, 1, 1};
    tbl[2] = '{32'd100, 1'b0, 16'd2, 32'd1, 3, 1,   2, 2, 1};
    tbl[3] = '{32'd7,   1'b1, 16'd4, 32'd3, 2, 6,   4, 4, 1};

    areset = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("reset_rx_start", int'(rx_start), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_frame_cnt", int'(frame_cnt), 0);
    chk("reset_rx_dsize", int'(rx_dsize), 0);
    chk("reset_rx_test", int'(rx_test), 0);
    chk("reset_err", int'(err_timeout), 0);

    // Simultaneous run and stop in IDLE: nothing happens.
    cfg_dsize = 32'h1234;
    cfg_test  = 1'b1;
    cmd_run   = 1'b1;
    cmd_stop  = 1'b1;
    @(negedge aclk);
    cmd_run  = 1'b0;
    cmd_stop = 1'b0;
    chk("runstop_busy", int'(busy), 0);
    chk("runstop_rx_dsize", int'(rx_dsize), 0);
    chk("runstop_rx_test", int'(rx_test), 0);
    @(negedge aclk);
    chk("runstop_busy2", int'(busy), 0);

    for (int t = 0; t < 4; t++) run_check(tbl[t], $sformatf("tbl%0d", t));

    for (int r = 0; r < 8; r++) begin
      vec_t v;
      v.dsize = $urandom;
      v.test  = 1'($urandom_range(0, 1));
      v.nfr   = 16'($urandom_range(1, 4));
      v.dly   = $urandom_range(0, 6);
      v.ldrop = int'($urandom_range(1, 3));
      v.lbusy = int'($urandom_range(1, 12));
      v = ref_model(v);
      run_check(v, $sformatf("rnd%0d", r));
    end

    // Trigger mode: edges outside WAIT_TRIG are discarded.
    cfg_trig_en = 1'b1;
    cfg_nframes = 16'd2;
    cfg_delay   = 32'd0;
    lat_drop    = 2;
    lat_busy    = 20;
    s0 = start_q.size();
    d0 = done_cnt;
    trig = 1'b1;
    @(negedge aclk);
    trig = 1'b0;
    @(negedge aclk);
    trig = 1'b1;
    pulse_run();
    trig = 1'b0;
    repeat (5) @(negedge aclk);
    chk("trig_idle_ignored", start_q.size() - s0, 0);
    trig = 1'b1;
    @(negedge aclk);
    trig_c1 = cyc;
    trig = 1'b0;
    wait_start(1'b1, 20, "trig1");
    wait_start(1'b0, 20, "trig1");
    trig = 1'b1;
    @(negedge aclk);
    trig = 1'b0;
    wait_fc(1, 200, "trig");
    repeat (5) @(negedge aclk);
    chk("trig_run_ignored", start_q.size() - s0, 1);
    trig = 1'b1;
    @(negedge aclk);
    trig_c2 = cyc;
    trig = 1'b0;
    wait_idle(200, "trig");
    @(negedge aclk);
    chk("trig_starts", start_q.size() - s0, 2);
    if (start_q.size() >= s0 + 2) begin
      chk("trig_lat1", start_q[s0] - trig_c1, 1);
      chk("trig_lat2", start_q[s0 + 1] - trig_c2, 1);
    end
    chk("trig_frame_cnt", int'(frame_cnt), 2);
    chk("trig_done", done_cnt - d0, 1);
    $display("run trig: frames=%0d done=%0d", frame_cnt, done_cnt - d0);
    cfg_trig_en = 1'b0;

    // Continuous mode, stop during the inter-frame delay.
    cfg_nframes = 16'd0;
    cfg_delay   = 32'd10;
    lat_drop    = 2;
    lat_busy    = 5;
    d0 = done_cnt;
    pulse_run();
    wait_fc(4, 2000, "stopdly");
    pulse_stop();
    chk("stopdly_busy", int'(busy), 0);
    @(negedge aclk);
    chk("stopdly_frame_cnt", int'(frame_cnt), 4);
    chk("stopdly_done", done_cnt - d0, 0);
    $display("run stopdly: frames=%0d done=%0d", frame_cnt, done_cnt - d0);

    // Continuous mode, stop during a frame: that frame still completes.
    d0 = done_cnt;
    pulse_run();
    wait_fc(4, 2000, "stoprun");
    wait_start(1'b1, 100, "stoprun");
    wait_start(1'b0, 100, "stoprun");
    pulse_stop();
    wait_idle(200, "stoprun");
    @(negedge aclk);
    chk("stoprun_frame_cnt", int'(frame_cnt), 5);
    chk("stoprun_done", done_cnt - d0, 1);
    $display("run stoprun: frames=%0d done=%0d", frame_cnt, done_cnt - d0);

    // Receiver never acknowledges: start times out.
    cfg_delay   = 32'd0;
    cfg_nframes = 16'd1;
    rx_force    = 1'b1;
    rx_mode     = 1'b1;
    @(negedge aclk);
    h0 = start_hi;
    d0 = done_cnt;
    pulse_run();
    wait_idle(3000, "tmo");
    @(negedge aclk);
    chk("tmo_start_cycles", start_hi - h0, ACK_TO);
    chk("tmo_err", int'(err_timeout), 1);
    chk("tmo_done", done_cnt - d0, 0);
    chk("tmo_frame_cnt", int'(frame_cnt), 0);
    $display("run tmo: start_cycles=%0d err=%0d", start_hi - h0, err_timeout);
    rx_mode = 1'b0;
    @(negedge aclk);
    pulse_run();
    chk("tmo_err_cleared", int'(err_timeout), 0);
    wait_idle(200, "tmo_rerun");
    @(negedge aclk);
    chk("tmo_rerun_frame_cnt", int'(frame_cnt), 1);

    // Receiver still initialising: no start until rx_pc rises, no timeout.
    rx_force = 1'b0;
    rx_mode  = 1'b1;
    @(negedge aclk);
    h0 = start_hi;
    s0 = start_q.size();
    d0 = done_cnt;
    pulse_run();
    repeat (ACK_TO) @(negedge aclk);
    chk("init_no_start", start_hi - h0, 0);
    chk("init_busy", int'(busy), 1);
    chk("init_err", int'(err_timeout), 0);
    rx_mode = 1'b0;
    wait_idle(200, "init");
    @(negedge aclk);
    chk("init_starts", start_q.size() - s0, 1);
    chk("init_frame_cnt", int'(frame_cnt), 1);
    chk("init_done", done_cnt - d0, 1);
    chk("init_err_end", int'(err_timeout), 0);
    $display("run init: frames=%0d err=%0d", frame_cnt, err_timeout);

    // Reset in the middle of frame 2.
    cfg_nframes = 16'd3;
    cfg_dsize   = 32'hABCD;
    cfg_test    = 1'b1;
    lat_drop    = 2;
    lat_busy    = 30;
    d0 = done_cnt;
    pulse_run();
    wait_fc(1, 200, "rst");
    wait_start(1'b1, 100, "rst");
    wait_start(1'b0, 100, "rst");
    areset = 1'b1;
    @(negedge aclk);
    chk("rst_rx_start", int'(rx_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_rx_dsize", int'(rx_dsize), 0);
    chk("rst_rx_test", int'(rx_test), 0);
    chk("rst_err", int'(err_timeout), 0);
    areset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (rx_pc) break;
    end
    chk("rst_no_done", done_cnt - d0, 0);
    $display("run rst: frame_cnt=%0d busy=%0d", frame_cnt, busy);
    pr = '{32'd9, 1'b0, 16'd2, 32'd2, 2, 4, 2, 2, 1};
    run_check(pr, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
